// File: rtl/cpu_timing_pkg.sv
// Shared encodings for the CPU timing block: CPU clock dividers, INT FSM states
// and the CPU bus view carried into the timing logic.
package common;

   localparam logic [1:0] CPUDIV_14  = 2'd0;
   localparam logic [1:0] CPUDIV_7   = 2'd1;
   localparam logic [1:0] CPUDIV_35  = 2'd2;
   localparam logic [1:0] CPUDIV_175 = 2'd3;

   typedef enum logic [1:0] {
      INT_IDLE   = 2'd0,
      INT_ARM    = 2'd1,
      INT_ACTIVE = 2'd2
   } int_state_t;

   typedef struct packed {
      logic [15:0] a;
      logic        mreq;
      logic        iorq;
      logic        rd;
      logic        wr;
      logic        rfsh;
   } cpu_bus_t;

   // Last half-period count value before clkcpu toggles (2^div - 1).
   function automatic logic [2:0] half_limit(input logic [1:0] div);
      case (div)
         CPUDIV_14: half_limit = 3'd0;
         CPUDIV_7:  half_limit = 3'd1;
         CPUDIV_35: half_limit = 3'd3;
         default:   half_limit = 3'd7;
      endcase
   endfunction

endpackage

// File: rtl/cpu_wait_gen.sv
// Access-start detector and per-access wait counter; hold stays high while
// the counter is nonzero.
module cpu_wait_gen
   import common::*;
#(
   parameter int WAIT_W = 4
) (
   input  logic              clk28,
   input  logic              rst,
   input  logic              rd,
   input  logic              wr,
   input  logic              iorq,
   input  logic [WAIT_W-1:0] mem_wait,
   input  logic [WAIT_W-1:0] io_wait,
   output logic              hold
);

   logic              rw_p1;
   logic              start;
   logic [WAIT_W-1:0] cnt;

   assign start = (rd | wr) & ~rw_p1;

   // A fresh access start always reloads, even over a running count.
   always_ff @(posedge clk28) begin
      if (rst) begin
         rw_p1 <= 1'b0;
         cnt   <= '0;
      end else begin
         rw_p1 <= rd | wr;
         if (start) begin
            cnt <= iorq ? io_wait : mem_wait;
         end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
         end
      end
   end

   assign hold = (cnt != '0);

endmodule

// File: rtl/cpu_timing.sv
// CPU clock generator with wait/contention freeze and raster-timed Z80 INT.
// Optional macro CPU_TIMING_TSTATE_EN adds a saturating T-state counter.
module cpu_timing
   import common::*;
#(
   parameter int HC_W     = 9,
   parameter int VC_W     = 9,
   parameter int INTLEN_W = 6,
   parameter int WAIT_W   = 4
) (
   input  logic                clk28,
   input  logic                rst,
   input  cpu_bus_t            bus,
   input  logic [1:0]          div,
   input  logic [HC_W-1:0]     hc,
   input  logic [VC_W-1:0]     vc,
   input  logic [HC_W-1:0]     int_h,
   input  logic [VC_W-1:0]     int_v,
   input  logic [INTLEN_W-1:0] int_len,
   input  logic                screen_contention,
   input  logic                cont_en,
   input  logic                cont_page,
   input  logic [WAIT_W-1:0]   mem_wait,
   input  logic [WAIT_W-1:0]   io_wait,
   output logic                clkcpu,
   output logic                clkcpu_ck,
   output logic                clkwait,
   output logic                n_int,
   output logic [15:0]         tstate
);

   logic [1:0]          div_p1;
   logic [2:0]          half_cnt;
   logic                toggle;
   logic                rise;
   logic                wait_hold;
   logic                cont_hold;
   logic                cont_addr;
   logic                cont_mem;
   logic                cont_io;
   logic                mreq_p1;
   logic                iorq_p1;
   logic                match;
   int_state_t          state_q;
   int_state_t          state_d;
   logic                n_int_d;
   logic [INTLEN_W-1:0] pulse_q;
   logic [INTLEN_W-1:0] pulse_d;
   logic                unused_bus;

   assign unused_bus = ^{bus.rfsh, bus.a[13:1]};

   cpu_wait_gen #(.WAIT_W(WAIT_W)) u_wait (
      .clk28    (clk28),
      .rst      (rst),
      .rd       (bus.rd),
      .wr       (bus.wr),
      .iorq     (bus.iorq),
      .mem_wait (mem_wait),
      .io_wait  (io_wait),
      .hold     (wait_hold)
   );

   assign cont_addr = bus.a[14] & (~bus.a[15] | cont_page);
   assign cont_mem  = cont_addr & bus.mreq & ~mreq_p1 & ~iorq_p1;
   assign cont_io   = bus.iorq & ~bus.a[0];
   assign cont_hold = clkcpu & screen_contention & cont_en & (div == CPUDIV_35)
                    & (cont_mem | cont_io);
   assign clkwait   = wait_hold | cont_hold;

   // div is only picked up at a toggle, so a half period is never cut short.
   assign toggle = ~clkwait & (half_cnt == half_limit(div_p1));
   assign rise   = toggle & ~clkcpu;

   always_ff @(posedge clk28) begin
      if (rst) begin
         clkcpu    <= 1'b0;
         clkcpu_ck <= 1'b0;
         half_cnt  <= 3'd0;
         div_p1    <= CPUDIV_14;
         mreq_p1   <= 1'b0;
         iorq_p1   <= 1'b0;
      end else begin
         clkcpu_ck <= rise;
         if (toggle) begin
            clkcpu   <= ~clkcpu;
            half_cnt <= 3'd0;
            div_p1   <= div;
         end else if (!clkwait) begin
            half_cnt <= half_cnt + 3'd1;
         end
         if (rise) begin
            mreq_p1 <= bus.mreq;
            iorq_p1 <= bus.iorq;
         end
      end
   end

   assign match = (hc == int_h) && (vc == int_v) && (int_len != '0);

   always_ff @(posedge clk28) begin
      if (rst) begin
         state_q <= INT_IDLE;
         n_int   <= 1'b1;
         pulse_q <= '0;
      end else begin
         state_q <= state_d;
         n_int   <= n_int_d;
         pulse_q <= pulse_d;
      end
   end

   // FSM events use the pre-strobe edge so n_int moves together with clkcpu_ck.
   always_comb begin
      state_d = state_q;
      n_int_d = n_int;
      pulse_d = pulse_q;
      case (state_q)
         INT_IDLE: begin
            if (match) state_d = INT_ARM;
         end
         INT_ARM: begin
            if (rise) begin
               state_d = INT_ACTIVE;
               n_int_d = 1'b0;
               pulse_d = INTLEN_W'(1);
            end
         end
         INT_ACTIVE: begin
            if (rise) begin
               if (pulse_q >= int_len) begin
                  state_d = INT_IDLE;
                  n_int_d = 1'b1;
                  pulse_d = '0;
               end else begin
                  pulse_d = pulse_q + 1'b1;
               end
            end
         end
         default: begin
            state_d = INT_IDLE;
            n_int_d = 1'b1;
            pulse_d = '0;
         end
      endcase
   end

`ifdef CPU_TIMING_TSTATE_EN
   logic        activate;
   logic [15:0] tstate_q;

   function automatic logic [15:0] sat_inc(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

   assign activate = (state_q == INT_ARM) & rise;

   always_ff @(posedge clk28) begin
      if (rst) begin
         tstate_q <= 16'd0;
      end else if (activate) begin
         tstate_q <= 16'd0;
      end else if (rise) begin
         tstate_q <= sat_inc(tstate_q);
      end
   end

   assign tstate = tstate_q;
`else
   assign tstate = 16'd0;
`endif

endmodule

// File: tb/tb_cpu_timing.sv
// Directed and randomized bench for cpu_timing against a cycle-level
// behavioural model built from the timing rules.
module tb_cpu_timing;
   import common::*;

   localparam int HC_W     = 9;
   localparam int VC_W     = 9;
   localparam int INTLEN_W = 6;
   localparam int WAIT_W   = 4;

   logic                clk28 = 1'b0;
   logic                rst;
   cpu_bus_t            bus;
   logic [1:0]          div;
   logic [HC_W-1:0]     hc;
   logic [VC_W-1:0]     vc;
   logic [HC_W-1:0]     int_h;
   logic [VC_W-1:0]     int_v;
   logic [INTLEN_W-1:0] int_len;
   logic                screen_contention;
   logic                cont_en;
   logic                cont_page;
   logic [WAIT_W-1:0]   mem_wait;
   logic [WAIT_W-1:0]   io_wait;
   logic                clkcpu;
   logic                clkcpu_ck;
   logic                clkwait;
   logic                n_int;
   logic [15:0]         tstate;

   always #5 clk28 = ~clk28;

   cpu_timing #(.HC_W(HC_W), .VC_W(VC_W), .INTLEN_W(INTLEN_W), .WAIT_W(WAIT_W)) dut (
      .clk28             (clk28),
      .rst               (rst),
      .bus               (bus),
      .div               (div),
      .hc                (hc),
      .vc                (vc),
      .int_h             (int_h),
      .int_v             (int_v),
      .int_len           (int_len),
      .screen_contention (screen_contention),
      .cont_en           (cont_en),
      .cont_page         (cont_page),
      .mem_wait          (mem_wait),
      .io_wait           (io_wait),
      .clkcpu            (clkcpu),
      .clkcpu_ck         (clkcpu_ck),
      .clkwait           (clkwait),
      .n_int             (n_int),
      .tstate            (tstate)
   );

   int checks = 0;
   int errors = 0;

   // Reference model: clock level progress, pending waits, INT pulse tally.
   bit m_clk, m_ck, m_nint, m_rw_prev, m_mreq_r, m_iorq_r, m_armed, m_active;
   int m_elapsed, m_half, m_wait, m_pulses, m_tstate;
   int n_ck, n_wait, n_lowck, n_lowcyc;

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_clk = 0; m_ck = 0; m_nint = 1; m_rw_prev = 0; m_mreq_r = 0; m_iorq_r = 0;
      m_armed = 0; m_active = 0; m_elapsed = 0; m_half = 1; m_wait = 0;
      m_pulses = 0; m_tstate = 0;
   endtask

   function automatic bit contention_now();
      bit caddr, mem, io;
      caddr = bus.a[14] && (!bus.a[15] || cont_page);
      mem   = caddr && bus.mreq && !m_mreq_r && !m_iorq_r;
      io    = bus.iorq && !bus.a[0];
      return m_clk && screen_contention && cont_en && (div == 2'd2) && (mem || io);
   endfunction

   task automatic step();
      bit hold_now, start, rise, match, activated;
      int exp_ts;
      @(negedge clk28);
      hold_now = (m_wait > 0) || contention_now();
      check("clkwait", 16'(clkwait), 16'(hold_now));
      if (clkwait === 1'b1) n_wait++;
      if (rst) begin
         model_reset();
      end else begin
         start = (bus.rd || bus.wr) && !m_rw_prev;
         m_rw_prev = bus.rd || bus.wr;
         if (start) m_wait = bus.iorq ? int'(io_wait) : int'(mem_wait);
         else if (m_wait > 0) m_wait--;
         rise = 0;
         if (!hold_now) begin
            m_elapsed++;
            if (m_elapsed == m_half) begin
               m_clk = !m_clk;
               rise = m_clk;
               m_elapsed = 0;
               m_half = 2 ** int'(div);
            end
         end
         if (rise) begin
            m_mreq_r = bus.mreq;
            m_iorq_r = bus.iorq;
         end
         m_ck = rise;
         match = (hc == int_h) && (vc == int_v) && (int_len != 0);
         activated = 0;
         if (m_active) begin
            if (rise) begin
               if (m_pulses >= int'(int_len)) begin
                  m_active = 0;
                  m_nint = 1;
               end else begin
                  m_pulses++;
               end
            end
         end else if (m_armed) begin
            if (rise) begin
               m_armed = 0; m_active = 1; m_nint = 0; m_pulses = 1; activated = 1;
            end
         end else if (match) begin
            m_armed = 1;
         end
         if (activated) m_tstate = 0;
         else if (rise && m_tstate < 65535) m_tstate++;
      end
      @(posedge clk28);
      #1;
`ifdef CPU_TIMING_TSTATE_EN
      exp_ts = m_tstate;
`else
      exp_ts = 0;
`endif
      check("clkcpu", 16'(clkcpu), 16'(m_clk));
      check("clkcpu_ck", 16'(clkcpu_ck), 16'(m_ck));
      check("n_int", 16'(n_int), 16'(m_nint));
      check("tstate", tstate, 16'(exp_ts));
      if (clkcpu_ck === 1'b1) n_ck++;
      if (clkcpu_ck === 1'b1 && n_int === 1'b0) n_lowck++;
      if (n_int === 1'b0) n_lowcyc++;
   endtask

   task automatic wait_rise(input string tag, output int cycles);
      cycles = 0;
      do begin
         step();
         cycles++;
      end while (clkcpu_ck !== 1'b1 && cycles < 200);
      check(tag, 16'(clkcpu_ck), 16'd1);
   endtask

   task automatic int_trigger();
      hc = 9'd4; vc = 9'd248;
      step();
      hc = 9'd0; vc = 9'd0;
   endtask

   task automatic wait_nint(input string tag, input logic lvl);
      int c;
      c = 0;
      while (n_int !== lvl && c < 300) begin
         step();
         c++;
      end
      check(tag, 16'(n_int), 16'(lvl));
   endtask

   initial begin
      int c, k0, w0, l0, exp100;
      rst = 1'b1; bus = '0; div = 2'd0; hc = '0; vc = '0;
      int_h = 9'd4; int_v = 9'd248; int_len = '0;
      screen_contention = 1'b0; cont_en = 1'b0; cont_page = 1'b0;
      mem_wait = '0; io_wait = '0;
      model_reset();
      n_ck = 0; n_wait = 0; n_lowck = 0; n_lowcyc = 0;
      step(); step();
      check("rst_clkcpu", 16'(clkcpu), 16'd0);
      check("rst_ck", 16'(clkcpu_ck), 16'd0);
      check("rst_clkwait", 16'(clkwait), 16'd0);
      check("rst_nint", 16'(n_int), 16'd1);
      check("rst_tstate", tstate, 16'd0);
      rst = 1'b0;

      // Clock periods at the fastest and slowest divider.
      wait_rise("rise_t", c);
      k0 = n_ck;
      wait_rise("rise_t", c);
      check("div0_period", 16'(c), 16'd2);
      check("div0_ck_per", 16'(n_ck - k0), 16'd1);
      div = 2'd3;
      wait_rise("rise_t", c); wait_rise("rise_t", c);
      k0 = n_ck;
      wait_rise("rise_t", c);
      check("div3_period", 16'(c), 16'd16);
      check("div3_ck_per", 16'(n_ck - k0), 16'd1);

      // Memory and IO wait insertion at 3.5 MHz.
      div = 2'd2; mem_wait = 4'd3;
      wait_rise("rise_t", c); wait_rise("rise_t", c);
      bus.rd = 1'b1; bus.mreq = 1'b1;
      w0 = n_wait;
      wait_rise("rise_t", c);
      check("memwait_period", 16'(c), 16'd11);
      check("memwait_cycles", 16'(n_wait - w0), 16'd3);
      bus.rd = 1'b0; bus.mreq = 1'b0;
      wait_rise("rise_t", c);
      check("after_wait_period", 16'(c), 16'd8);
      mem_wait = 4'd0; bus.rd = 1'b1; bus.mreq = 1'b1;
      wait_rise("rise_t", c);
      check("zero_wait_period", 16'(c), 16'd8);
      bus.rd = 1'b0; bus.mreq = 1'b0;
      wait_rise("rise_t", c);
      io_wait = 4'd5; bus.wr = 1'b1; bus.iorq = 1'b1; bus.a = 16'h0001;
      wait_rise("rise_t", c);
      check("iowait_period", 16'(c), 16'd13);
      bus.wr = 1'b0; bus.iorq = 1'b0; bus.a = 16'h0000;
      wait_rise("rise_t", c);

      // Screen contention holds clkcpu high until the window closes.
      cont_en = 1'b1; screen_contention = 1'b1; bus.a = 16'h4000;
      wait_rise("rise_t", c);
      bus.mreq = 1'b1;
      w0 = n_wait;
      repeat (20) step();
      check("cont_clk_high", 16'(clkcpu), 16'd1);
      check("cont_hold_cycles", 16'(n_wait - w0), 16'd20);
      screen_contention = 1'b0;
      wait_rise("cont_release", c);
      check("cont_resume_period", 16'(c), 16'd8);
      bus.mreq = 1'b0;

      // No hold with contention disabled, nor at 14 MHz.
      cont_en = 1'b0; screen_contention = 1'b1;
      wait_rise("rise_t", c);
      bus.mreq = 1'b1;
      w0 = n_wait;
      wait_rise("rise_t", c);
      check("cont_off_period", 16'(c), 16'd8);
      check("cont_off_waits", 16'(n_wait - w0), 16'd0);
      bus.mreq = 1'b0; cont_en = 1'b1; div = 2'd0;
      wait_rise("rise_t", c); wait_rise("rise_t", c);
      bus.mreq = 1'b1;
      w0 = n_wait;
      wait_rise("rise_t", c);
      check("cont_div0_period", 16'(c), 16'd2);
      check("cont_div0_waits", 16'(n_wait - w0), 16'd0);
      bus.mreq = 1'b0; screen_contention = 1'b0; cont_en = 1'b0; bus.a = 16'h0000;

      // INT pulse length and disable.
      int_len = 6'd32;
      l0 = n_lowck;
      int_trigger();
      wait_nint("int_fall", 1'b0);
      wait_nint("int_release", 1'b1);
      check("int_low_cks", 16'(n_lowck - l0), 16'd32);
      int_len = 6'd0;
      l0 = n_lowcyc;
      int_trigger();
      repeat (60) step();
      check("int_disabled_low", 16'(n_lowcyc - l0), 16'd0);

      // Reset in the middle of an INT.
      int_len = 6'd20;
      int_trigger();
      wait_nint("int_fall2", 1'b0);
      repeat (6) step();
      rst = 1'b1;
      step();
      check("midrst_nint", 16'(n_int), 16'd1);
      check("midrst_tstate", tstate, 16'd0);
      check("midrst_clkcpu", 16'(clkcpu), 16'd0);
      rst = 1'b0;

      // T-state count 100 strobes after INT start.
      int_len = 6'd10;
      int_trigger();
      wait_nint("int_fall3", 1'b0);
      repeat (100) wait_rise("rise_t", c);
`ifdef CPU_TIMING_TSTATE_EN
      exp100 = 100;
`else
      exp100 = 0;
`endif
      check("tstate_100", tstate, 16'(exp100));

      // Randomized traffic against the model.
      for (int i = 0; i < 1500; i++) begin
         rst = ($urandom_range(0, 299) == 0);
         if ($urandom_range(0, 49) == 0) div = 2'($urandom_range(0, 3));
         if ($urandom_range(0, 3) == 0) bus.rd = ($urandom_range(0, 2) == 0);
         if ($urandom_range(0, 3) == 0) bus.wr = ($urandom_range(0, 4) == 0);
         bus.mreq = ($urandom_range(0, 1) == 1);
         bus.iorq = ($urandom_range(0, 5) == 0);
         bus.rfsh = ($urandom_range(0, 7) == 0);
         if ($urandom_range(0, 7) == 0) begin
            case ($urandom_range(0, 3))
               0: bus.a = 16'h4000;
               1: bus.a = 16'hC000;
               2: bus.a = 16'h40FE;
               default: bus.a = 16'($urandom_range(0, 65535));
            endcase
         end
         if ($urandom_range(0, 7) == 0) screen_contention = ~screen_contention;
         if ($urandom_range(0, 31) == 0) cont_en = ~cont_en;
         if ($urandom_range(0, 31) == 0) cont_page = ~cont_page;
         if ($urandom_range(0, 19) == 0) begin
            mem_wait = 4'($urandom_range(0, 15));
            io_wait  = 4'($urandom_range(0, 15));
         end
         if ($urandom_range(0, 29) == 0) int_len = 6'($urandom_range(0, 6));
         hc = 9'($urandom_range(0, 15));
         vc = ($urandom_range(0, 3) == 0) ? 9'd248 : 9'd100;
         step();
      end
      rst = 1'b0;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
